// File: rtl/motor_dense_seq_relu_in.sv
// motor_dense_seq_relu_in: one-MAC dense layer after ReLU; weights/biases from a sync ROM, Q7.11 wrapped outputs
module motor_dense_seq_relu_in #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int ACC_W = 40,
  localparam int W_AW = $clog2(N_IN * N_OUT),
  localparam int B_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int IW   = $clog2(N_IN)
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic [16:0]     in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W_AW-1:0] w_addr,
  output logic [B_AW-1:0] b_addr,
  output logic            rom_en,
  input  logic [17:0]     w_q,
  input  logic [17:0]     b_q,
  output logic [17:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last
);
  typedef enum logic [1:0] {S_LOAD, S_MAC, S_FLUSH, S_OUT} state_t;
  state_t            state_q;
  logic [IW-1:0]     i_q, k_q;
  logic [B_AW-1:0]   neuron_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              mac_v_q, first_q, in_ready_q, out_valid_q, out_last_q;
  logic [17:0]       out_data_q;
  logic [16:0]       buf_q [N_IN];
  logic signed [35:0] prod;
  logic              take, last_i;
  assign take      = in_valid && in_ready_q;
  assign last_i    = i_q == IW'(N_IN - 1);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rom_en    = state_q == S_MAC;
  assign w_addr    = rom_en ? W_AW'(neuron_q) * W_AW'(N_IN) + W_AW'(i_q) : '0;
  assign b_addr    = rom_en ? neuron_q : '0;
  // ROM data lags the address by one cycle; k_q/first_q track which sample it belongs to
  always_comb begin
    prod  = $signed({1'b0, buf_q[k_q]}) * $signed(w_q);
    acc_d = (first_q ? {{(ACC_W-18){b_q[17]}}, b_q} << 11 : acc_q) + {{(ACC_W-36){prod[35]}}, prod};
  end
  always_ff @(posedge ap_clk) begin
    if (take) buf_q[i_q] <= in_data;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_LOAD;
      i_q         <= '0;
      k_q         <= '0;
      neuron_q    <= '0;
      acc_q       <= '0;
      mac_v_q     <= 1'b0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mac_v_q <= state_q == S_MAC;
      first_q <= state_q == S_MAC && i_q == '0;
      k_q     <= i_q;
      if (mac_v_q) acc_q <= acc_d;
      case (state_q)
        S_LOAD: begin
          in_ready_q <= !(take && last_i);
          if (take) begin
            i_q <= last_i ? '0 : i_q + 1'b1;
            if (last_i) begin
              state_q  <= S_MAC;
              neuron_q <= '0;
            end
          end
        end
        S_MAC: begin
          i_q <= last_i ? '0 : i_q + 1'b1;
          if (last_i) state_q <= S_FLUSH;
        end
        S_FLUSH: state_q <= S_OUT;
        default: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q[28:11];
            out_last_q  <= neuron_q == B_AW'(N_OUT - 1);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              neuron_q <= neuron_q + 1'b1;
              state_q  <= S_MAC;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_motor_dense_seq_relu_in.sv
// tb_motor_dense_seq_relu_in: randomized + directed bench with a queue-based neuron reference model
module tb_motor_dense_seq_relu_in;
  localparam int NI  = 4;
  localparam int NO  = 2;
  localparam int WAW = $clog2(NI * NO);
  localparam int BAW = (NO > 1) ? $clog2(NO) : 1;

  logic ap_clk = 1'b0, ap_rst_n;
  logic [16:0] in_data;
  logic in_valid, in_ready, rom_en, out_valid, out_ready, out_last;
  logic [WAW-1:0] w_addr;
  logic [BAW-1:0] b_addr;
  logic [17:0] w_q, b_q, out_data;

  motor_dense_seq_relu_in #(.N_IN(NI), .N_OUT(NO), .ACC_W(40)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w_addr(w_addr), .b_addr(b_addr), .rom_en(rom_en),
    .w_q(w_q), .b_q(b_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last));

  always #5 ap_clk = ~ap_clk;

  typedef struct packed { logic [17:0] d; logic l; } exp_t;
  logic [17:0] wrom [NI*NO];
  logic [17:0] brom [NO];
  exp_t        expq [$];
  logic [16:0] col [$];
  logic [16:0] va [NI];
  logic [17:0] got [$];
  int errors = 0, checks = 0, cyc = 0, due = -1, ready_mode = 0, gap_max = 0;
  bit ready_next = 0;

  always @(posedge ap_clk) if (rom_en) begin
    w_q <= wrom[w_addr];
    b_q <= brom[b_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Real-valued neuron: bias*2^11 + sum(x*w) with all fractional bits, then keep Q7.11 window
  function automatic logic [17:0] neuron_ref(input logic [16:0] v [NI], input int n);
    longint s;
    logic [63:0] a;
    s = longint'($signed(brom[n])) * 2048;
    for (int i = 0; i < NI; i++) s += longint'(v[i]) * longint'($signed(wrom[n*NI+i]));
    a = s;
    return a[28:11];
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_w_addr", w_addr, 0);
      chk("rst_b_addr", b_addr, 0);
      col.delete();
      expq.delete();
      due = -1;
      ready_next = 0;
    end else begin
      cyc++;
      if (expq.size() != 0) chk("in_ready_busy", in_ready, 0);
      if (ready_next) begin
        chk("in_ready_return", in_ready, 1);
        ready_next = 0;
      end
      if (due >= 0) begin
        if (cyc < due) chk("early_valid", out_valid, 0);
        else begin
          chk("latency", out_valid, 1);
          due = -1;
        end
      end
      if (!out_valid) chk("last_without_valid", out_last, 0);
      else begin
        chk("rom_en_in_out", rom_en, 0);
        if (expq.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("out_data", out_data, expq[0].d);
          chk("out_last", out_last, expq[0].l);
          if (out_ready) begin
            got.push_back(out_data);
            void'(expq.pop_front());
            if (expq.size() != 0) due = cyc + NI + 3;
            else ready_next = 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        col.push_back(in_data);
        if (col.size() == NI) begin
          foreach (va[i]) va[i] = col[i];
          for (int n = 0; n < NO; n++) expq.push_back('{d: neuron_ref(va, n), l: n == NO - 1});
          due = cyc + NI + 3;
          col.delete();
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge ap_clk); #1;
      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic send(input logic [16:0] d);
    int t = 0;
    in_data = d;
    in_valid = 1'b1;
    @(negedge ap_clk);
    while (!in_ready && t < 200) begin t++; @(negedge ap_clk); end
    chk("send_accept", in_ready, 1);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_data = 17'($urandom);
    repeat ($urandom_range(0, gap_max)) begin @(posedge ap_clk); #1; end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge ap_clk);
    while ((expq.size() != 0 || !in_ready) && t < 1000) begin t++; @(negedge ap_clk); end
    chk("idle_reached", t < 1000, 1);
    @(posedge ap_clk); #1;
  endtask

  task automatic set_rom(input logic [17:0] w, input logic [17:0] b);
    foreach (wrom[i]) wrom[i] = w;
    foreach (brom[i]) brom[i] = b;
  endtask

  task automatic run_dir(input string nm, input logic [16:0] x, input logic [17:0] w,
                         input logic [17:0] b, input logic [17:0] lit);
    logic [16:0] v [NI];
    set_rom(w, b);
    foreach (v[i]) v[i] = x;
    chk({nm, "_model"}, neuron_ref(v, NO - 1), lit);
    got.delete();
    foreach (v[i]) send(v[i]);
    wait_idle();
    chk({nm, "_beats"}, got.size(), NO);
    foreach (got[k]) chk(nm, got[k], lit);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_rom_en", rom_en, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_out_data", out_data, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    set_rom('0, '0);
    repeat (3) @(negedge ap_clk);
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    run_dir("unity",     17'd2048,  18'd2048,   18'd0,    18'h02000);
    run_dir("neg_w",     17'd4096,  18'h3FC00,  18'd512,  18'h3E200);
    run_dir("trunc_pos", 17'd1,     18'd1,      18'd0,    18'h00000);
    run_dir("trunc_neg", 17'd1,     18'h3FFFF,  18'd0,    18'h3FFFF);
    run_dir("wrap",      17'd65536, 18'd65536,  18'd0,    18'h00000);
    run_dir("wrap_bias", 17'd65536, 18'd65536,  18'd2048, 18'h00800);

    ready_mode = 2;
    set_rom(18'd2048, 18'd0);
    got.delete();
    repeat (NI) send(17'd2048);
    begin
      int t = 0;
      @(negedge ap_clk);
      while (!out_valid && t < 100) begin t++; @(negedge ap_clk); end
      chk("bp_valid_seen", out_valid, 1);
    end
    @(posedge ap_clk); #1;
    repeat (10) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 17'($urandom);
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_no_beats", got.size(), 0);
    ready_mode = 0;
    wait_idle();
    chk("bp_beats", got.size(), NO);

    send(17'h1234);
    send(17'h0777);
    do_reset();
    run_dir("post_rst_load", 17'd2048, 18'd2048, 18'd0, 18'h02000);

    set_rom(18'd77, 18'd5);
    repeat (NI) send(17'h1FFFF);
    @(posedge ap_clk); #2;
    chk("mac_active", rom_en, 1);
    do_reset();
    run_dir("post_rst_mac", 17'd4096, 18'h3FC00, 18'd512, 18'h3E200);

    ready_mode = 1;
    gap_max = 2;
    got.delete();
    for (int r = 0; r < 8; r++) begin
      foreach (wrom[i]) wrom[i] = 18'($urandom);
      foreach (brom[i]) brom[i] = 18'($urandom);
      for (int i = 0; i < NI; i++) send((r == 0) ? 17'h1FFFF : 17'($urandom));
      wait_idle();
    end
    chk("rand_beats", got.size(), 8 * NO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
